// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage load/store engine. Issues one transaction at a time on the
//   data-side SRAM-like bus (req / addr_ok / data_ok). Builds byte strobes and
//   replicated store data, detects misaligned accesses, and stalls the
//   pipeline while a transaction is in flight. The extended load result is
//   registered and held in DONE until the pipeline advances.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   mem_enM/mem_wenM/mem_sizeM/mem_signM  M-stage access descriptor
//   alu_outM, write_dataM         effective address, right-justified store data
//   flushM, pipe_stallM           cancel M instr / external stall
//   data_sram_*                   SRAM-like data bus
//   mem_rdataM                    extended load result (registered)
//   stallM, adelM, adesM, bad_addrM  stall request and address-error report
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_enM,
   input  logic        mem_wenM,
   input  logic [1:0]  mem_sizeM,
   input  logic        mem_signM,
   input  logic [31:0] alu_outM,
   input  logic [31:0] write_dataM,
   input  logic        flushM,
   input  logic        pipe_stallM,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [1:0]  data_sram_size,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   output logic [3:0]  data_sram_wstrb,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   output logic [31:0] mem_rdataM,
   output logic        stallM,
   output logic        adelM,
   output logic        adesM,
   output logic [31:0] bad_addrM
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

   state_e      state_q, state_d;
   logic        cancel_q, cancel_d;
   logic [31:0] rdata_q, rdata_d;

   logic        is_byte, is_half, is_word, mis, need;
   logic        req_c, stall_c;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] ld_ext;

   // size 3 is reserved and behaves as a word access
   assign is_byte = (mem_sizeM == 2'd0);
   assign is_half = (mem_sizeM == 2'd1);
   assign is_word = mem_sizeM[1];

   assign mis  = (is_half & alu_outM[0]) | (is_word & (alu_outM[1:0] != 2'b00));
   assign need = mem_enM & ~mis & ~flushM;

   assign adelM     = mem_enM & ~mem_wenM & mis;
   assign adesM     = mem_enM &  mem_wenM & mis;
   assign bad_addrM = alu_outM;

   // Bus request fields follow the M-stage inputs directly; the pipeline is
   // stalled while a request is pending, so they stay stable on their own.
   assign data_sram_wr   = mem_wenM;
   assign data_sram_size = mem_sizeM;
   assign data_sram_addr = alu_outM;

   always_comb begin
      data_sram_wstrb = 4'b0000;
      data_sram_wdata = write_dataM;
      if (is_byte) begin
         data_sram_wdata = {4{write_dataM[7:0]}};
         if (mem_wenM) data_sram_wstrb = 4'b0001 << alu_outM[1:0];
      end else if (is_half) begin
         data_sram_wdata = {2{write_dataM[15:0]}};
         if (mem_wenM) data_sram_wstrb = alu_outM[1] ? 4'b1100 : 4'b0011;
      end else begin
         if (mem_wenM) data_sram_wstrb = 4'b1111;
      end
   end

   // Load lane select and extension
   always_comb begin
      case (alu_outM[1:0])
         2'd0:    ld_b = data_sram_rdata[7:0];
         2'd1:    ld_b = data_sram_rdata[15:8];
         2'd2:    ld_b = data_sram_rdata[23:16];
         default: ld_b = data_sram_rdata[31:24];
      endcase
      ld_h = alu_outM[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
      if (is_byte)      ld_ext = {{24{mem_signM & ld_b[7]}}, ld_b};
      else if (is_half) ld_ext = {{16{mem_signM & ld_h[15]}}, ld_h};
      else              ld_ext = data_sram_rdata;
   end

   always_comb begin
      state_d  = state_q;
      cancel_d = cancel_q;
      rdata_d  = rdata_q;
      req_c    = 1'b0;
      stall_c  = 1'b0;
      case (state_q)
         IDLE: begin
            req_c   = need;
            stall_c = need;
            if (need) state_d = data_sram_addr_ok ? WAIT : REQ;
         end
         REQ: begin
            req_c   = 1'b1;
            stall_c = 1'b1;
            // data_ok in this state is illegal and ignored
            if (data_sram_addr_ok) begin
               state_d  = WAIT;
               cancel_d = flushM;   // accepted and flushed in the same cycle
            end else if (flushM) begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            stall_c = 1'b1;
            if (flushM) cancel_d = 1'b1;
            if (data_sram_data_ok) begin
               cancel_d = 1'b0;
               if (cancel_q | flushM) begin
                  state_d = IDLE;
               end else begin
                  state_d = DONE;
                  rdata_d = mem_wenM ? 32'h0 : ld_ext;
               end
            end
         end
         default: begin  // DONE: hold result, never re-issue
            if (flushM | ~pipe_stallM) state_d = IDLE;
         end
      endcase
      if (rst) begin
         req_c   = 1'b0;
         stall_c = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cancel_q <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         state_q  <= state_d;
         cancel_q <= cancel_d;
         rdata_q  <= rdata_d;
      end
   end

   assign data_sram_req = req_c;
   assign stallM        = stall_c;
   assign mem_rdataM    = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_enM = 1'b0, mem_wenM = 1'b0, mem_signM = 1'b0;
   logic [1:0]  mem_sizeM = 2'd2;
   logic [31:0] alu_outM = 32'h0, write_dataM = 32'h0;
   logic        flushM = 1'b0, pipe_stallM = 1'b0;
   logic        data_sram_req, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic [3:0]  data_sram_wstrb;
   logic        data_sram_addr_ok = 1'b0, data_sram_data_ok = 1'b0;
   logic [31:0] data_sram_rdata;
   logic [31:0] mem_rdataM, bad_addrM;
   logic        stallM, adelM, adesM;

   int nvec = 0;
   int nerr = 0;
   logic [31:0] exp_q[$];

   // slave model knobs: ack on the ack_dly-th request cycle, data_ok on the
   // data_dly-th cycle after acceptance
   int          ack_dly = 1, data_dly = 1;
   logic [31:0] rdata_val = 32'h0;
   int          rcnt = 0, wcnt = 0;
   logic        pending = 1'b0;

   assign data_sram_rdata = rdata_val;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .rst(rst),
      .mem_enM(mem_enM), .mem_wenM(mem_wenM), .mem_sizeM(mem_sizeM),
      .mem_signM(mem_signM), .alu_outM(alu_outM), .write_dataM(write_dataM),
      .flushM(flushM), .pipe_stallM(pipe_stallM),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
      .data_sram_wdata(data_sram_wdata), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata), .mem_rdataM(mem_rdataM),
      .stallM(stallM), .adelM(adelM), .adesM(adesM), .bad_addrM(bad_addrM)
   );

   always @(negedge clk) begin
      if (data_sram_addr_ok) begin pending = 1'b1; wcnt = 0; rcnt = 0; end
      if (data_sram_data_ok) pending = 1'b0;
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      if (rst) begin
         pending = 1'b0; rcnt = 0;
      end else if (pending) begin
         wcnt++;
         if (wcnt >= data_dly) data_sram_data_ok = 1'b1;
      end else if (data_sram_req) begin
         rcnt++;
         if (rcnt >= ack_dly) data_sram_addr_ok = 1'b1;
      end else begin
         rcnt = 0;
      end
   end

   // Drive one access and follow it until stallM drops (DONE, or no issue).
   task automatic run_op(input logic wen, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int stall_n, output int req_n, output logic [31:0] rd,
                         output logic tout, output logic [3:0] strb_s,
                         output logic [31:0] wdata_s, output logic wr_s,
                         output logic unstable);
      @(posedge clk); #1;
      mem_enM = 1'b1; mem_wenM = wen; mem_sizeM = size; mem_signM = sgn;
      alu_outM = addr; write_dataM = wd; flushM = 1'b0; pipe_stallM = 1'b0;
      stall_n = 0; req_n = 0; rd = 32'h0; tout = 1'b1; unstable = 1'b0;
      strb_s = 4'h0; wdata_s = 32'h0; wr_s = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (data_sram_req) begin
            if (req_n == 0) begin
               strb_s = data_sram_wstrb; wdata_s = data_sram_wdata; wr_s = data_sram_wr;
            end else if (strb_s !== data_sram_wstrb || wdata_s !== data_sram_wdata ||
                         data_sram_addr !== addr) begin
               unstable = 1'b1;
            end
            req_n++;
         end
         if (stallM) stall_n++;
         else begin tout = 1'b0; rd = mem_rdataM; break; end
      end
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      mem_enM = 1'b0; flushM = 1'b0; pipe_stallM = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_enM = 1'b1; alu_outM = 32'h1000_0004;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      nvec++; if (stallM !== 1'b0) begin nerr++; $display("FAIL reset_stall got %b want 0", stallM); end
      nvec++; if (data_sram_req !== 1'b0) begin nerr++; $display("FAIL reset_req got %b want 0", data_sram_req); end
      nvec++; if (mem_rdataM !== 32'h0) begin nerr++; $display("FAIL reset_rdata got %h want 0", mem_rdataM); end
      @(posedge clk); #1;
      rst = 1'b0; mem_enM = 1'b0;
   endtask

   task automatic test_aligned_load();
      int s, r; logic [31:0] rd, wd; logic [3:0] st; logic to, wr, un;
      ack_dly = 1; data_dly = 1; rdata_val = 32'hDEAD_BEEF;
      exp_q.push_back(32'hDEAD_BEEF);
      run_op(1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'h0, s, r, rd, to, st, wd, wr, un);
      nvec++; if (to) begin nerr++; $display("FAIL lw_timeout stall stuck high"); end
      nvec++; if (s != 2) begin nerr++; $display("FAIL lw_stall_cycles got %0d want 2", s); end
      nvec++; if (r != 1) begin nerr++; $display("FAIL lw_req_cycles got %0d want 1", r); end
      nvec++; if (st !== 4'b0000 || wr !== 1'b0) begin nerr++; $display("FAIL lw_strb got %b/%b want 0000/0", st, wr); end
      nvec++; if (rd !== exp_q[0]) begin nerr++; $display("FAIL lw_rdata got %h want %h", rd, exp_q[0]); end
      void'(exp_q.pop_front());
      go_idle();
   endtask

   task automatic test_extension();
      logic [1:0]  sz [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
      logic        sg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0]  lo [4] = '{2'd3, 2'd3, 2'd2, 2'd2};
      logic [31:0] ex [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
      int s, r; logic [31:0] rd, wd; logic [3:0] st; logic to, wr, un;
      ack_dly = 1; data_dly = 1; rdata_val = 32'h80FF_7F01;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(ex[k]);
         run_op(1'b0, sz[k], sg[k], {30'h0400_0010, lo[k]}, 32'h0, s, r, rd, to, st, wd, wr, un);
         nvec++;
         if (to || rd !== exp_q[0]) begin
            nerr++; $display("FAIL ext_%0d got %h want %h (timeout=%b)", k, rd, exp_q[0], to);
         end
         void'(exp_q.pop_front());
         go_idle();
      end
   endtask

   task automatic test_store_strobes();
      int s, r; logic [31:0] rd, wd; logic [3:0] st; logic to, wr, un;
      ack_dly = 1; data_dly = 1; rdata_val = 32'h5555_5555;
      exp_q.push_back(32'h0);
      run_op(1'b1, 2'd0, 1'b0, 32'h1000_0011, 32'h0000_00AB, s, r, rd, to, st, wd, wr, un);
      nvec++; if (st !== 4'b0010) begin nerr++; $display("FAIL sb_strb got %b want 0010", st); end
      nvec++; if (wd !== 32'hABAB_ABAB) begin nerr++; $display("FAIL sb_wdata got %h want ababab", wd); end
      nvec++; if (wr !== 1'b1) begin nerr++; $display("FAIL sb_wr got %b want 1", wr); end
      nvec++; if (to || rd !== exp_q[0]) begin nerr++; $display("FAIL sb_result got %h want %h", rd, exp_q[0]); end
      void'(exp_q.pop_front());
      go_idle();
      exp_q.push_back(32'h0);
      run_op(1'b1, 2'd1, 1'b0, 32'h1000_0012, 32'h0000_1234, s, r, rd, to, st, wd, wr, un);
      nvec++; if (st !== 4'b1100) begin nerr++; $display("FAIL sh_strb got %b want 1100", st); end
      nvec++; if (wd !== 32'h1234_1234) begin nerr++; $display("FAIL sh_wdata got %h want 12341234", wd); end
      nvec++; if (to || rd !== exp_q[0]) begin nerr++; $display("FAIL sh_result got %h want %h", rd, exp_q[0]); end
      void'(exp_q.pop_front());
      go_idle();
   endtask

   task automatic test_addr_error();
      int s, r; logic [31:0] rd, wd; logic [3:0] st; logic to, wr, un;
      run_op(1'b0, 2'd2, 1'b0, 32'h1000_0002, 32'h0, s, r, rd, to, st, wd, wr, un);
      nvec++; if (adelM !== 1'b1 || adesM !== 1'b0) begin nerr++; $display("FAIL lw_adel got %b/%b want 1/0", adelM, adesM); end
      nvec++; if (bad_addrM !== 32'h1000_0002) begin nerr++; $display("FAIL lw_badaddr got %h want 10000002", bad_addrM); end
      nvec++; if (r != 0 || s != 0) begin nerr++; $display("FAIL lw_mis_issue got req=%0d stall=%0d want 0/0", r, s); end
      go_idle();
      run_op(1'b1, 2'd1, 1'b0, 32'h1000_0001, 32'h1234, s, r, rd, to, st, wd, wr, un);
      nvec++; if (adesM !== 1'b1 || adelM !== 1'b0) begin nerr++; $display("FAIL sh_ades got %b/%b want 1/0", adesM, adelM); end
      nvec++; if (r != 0 || s != 0) begin nerr++; $display("FAIL sh_mis_issue got req=%0d stall=%0d want 0/0", r, s); end
      go_idle();
   endtask

   task automatic test_backpressure();
      int s, r; logic [31:0] rd, wd; logic [3:0] st; logic to, wr, un;
      ack_dly = 3; data_dly = 3; rdata_val = 32'h0BAD_F00D;
      exp_q.push_back(32'h0BAD_F00D);
      run_op(1'b0, 2'd2, 1'b0, 32'h2000_0008, 32'h0, s, r, rd, to, st, wd, wr, un);
      // 3 request cycles plus 3 cycles to data_ok
      nvec++; if (to || s != 6) begin nerr++; $display("FAIL bp_stall got %0d want 6", s); end
      nvec++; if (r != 3) begin nerr++; $display("FAIL bp_req got %0d want 3", r); end
      nvec++; if (un) begin nerr++; $display("FAIL bp_stable request changed while pending"); end
      nvec++; if (rd !== exp_q[0]) begin nerr++; $display("FAIL bp_rdata got %h want %h", rd, exp_q[0]); end
      pipe_stallM = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); #1;
         nvec++;
         if (stallM !== 1'b0 || data_sram_req !== 1'b0 || mem_rdataM !== exp_q[0]) begin
            nerr++; $display("FAIL bp_hold_%0d got stall=%b req=%b rdata=%h want 0/0/%h",
                             k, stallM, data_sram_req, mem_rdataM, exp_q[0]);
         end
      end
      void'(exp_q.pop_front());
      pipe_stallM = 1'b0;
      go_idle();
   endtask

   task automatic test_flush_req();
      int s, r; logic [31:0] rd, wd; logic [3:0] st; logic to, wr, un;
      ack_dly = 100; data_dly = 1;
      @(posedge clk); #1;
      mem_enM = 1'b1; mem_wenM = 1'b0; mem_sizeM = 2'd2; alu_outM = 32'h3000_0000;
      @(negedge clk); #1;
      @(posedge clk); #1;
      flushM = 1'b1;
      @(negedge clk); #1;
      nvec++; if (data_sram_req !== 1'b1) begin nerr++; $display("FAIL flreq_inreq got %b want 1", data_sram_req); end
      @(posedge clk); #1;
      flushM = 1'b0; mem_enM = 1'b0;
      @(negedge clk); #1;
      nvec++; if (data_sram_req !== 1'b0 || stallM !== 1'b0) begin
         nerr++; $display("FAIL flreq_drop got req=%b stall=%b want 0/0", data_sram_req, stallM);
      end
      ack_dly = 1; data_dly = 1; rdata_val = 32'h1122_3344;
      exp_q.push_back(32'h1122_3344);
      run_op(1'b0, 2'd2, 1'b0, 32'h3000_0004, 32'h0, s, r, rd, to, st, wd, wr, un);
      nvec++; if (to || s != 2 || rd !== exp_q[0]) begin
         nerr++; $display("FAIL flreq_next got stall=%0d rdata=%h want 2/%h", s, rd, exp_q[0]);
      end
      void'(exp_q.pop_front());
      go_idle();
   endtask

   task automatic test_flush_wait();
      int n = 0; logic seen_req = 1'b0;
      ack_dly = 1; data_dly = 4; rdata_val = 32'h5566_7788;
      @(posedge clk); #1;
      mem_enM = 1'b1; mem_wenM = 1'b0; mem_sizeM = 2'd2; alu_outM = 32'h3000_0008;
      @(negedge clk); #1;
      @(posedge clk); #1;
      flushM = 1'b1; mem_enM = 1'b0;
      @(negedge clk); #1;
      if (stallM) n++;
      @(posedge clk); #1;
      flushM = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (data_sram_req) seen_req = 1'b1;
         if (stallM) n++; else break;
      end
      // WAIT lasts until the 4th cycle after acceptance
      nvec++; if (n != 4) begin nerr++; $display("FAIL flwait_stall got %0d want 4", n); end
      nvec++; if (seen_req) begin nerr++; $display("FAIL flwait_req request seen during WAIT"); end
      nvec++; if (mem_rdataM !== 32'h1122_3344) begin nerr++; $display("FAIL flwait_rdata got %h want 11223344", mem_rdataM); end
      go_idle();
   endtask

   task automatic test_rst_wait();
      ack_dly = 1; data_dly = 5; rdata_val = 32'hCAFE_F00D;
      @(posedge clk); #1;
      mem_enM = 1'b1; mem_wenM = 1'b0; mem_sizeM = 2'd2; alu_outM = 32'h3000_000C;
      @(negedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; mem_enM = 1'b0;
      @(negedge clk); #1;
      nvec++; if (stallM !== 1'b0 || data_sram_req !== 1'b0) begin
         nerr++; $display("FAIL rstwait_live got stall=%b req=%b want 0/0", stallM, data_sram_req);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      nvec++; if (mem_rdataM !== 32'h0 || stallM !== 1'b0) begin
         nerr++; $display("FAIL rstwait_after got rdata=%h stall=%b want 0/0", mem_rdataM, stallM);
      end
   endtask

   task automatic test_back_to_back();
      int s, r; logic [31:0] rd, wd; logic [3:0] st; logic to, wr, un;
      logic [31:0] vals [2] = '{32'hA5A5_0001, 32'h5A5A_0002};
      ack_dly = 1; data_dly = 1;
      for (int k = 0; k < 2; k++) begin
         rdata_val = vals[k];
         exp_q.push_back(vals[k]);
         run_op(1'b0, 2'd2, 1'b0, 32'h4000_0000 + 32'(k * 4), 32'h0, s, r, rd, to, st, wd, wr, un);
         nvec++;
         if (to || s != 2 || r != 1 || rd !== exp_q[0]) begin
            nerr++; $display("FAIL b2b_%0d got stall=%0d req=%0d rdata=%h want 2/1/%h", k, s, r, rd, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      go_idle();
   endtask

   initial begin
      test_reset();
      test_aligned_load();
      test_extension();
      test_store_strobes();
      test_addr_error();
      test_backpressure();
      test_flush_req();
      test_flush_wait();
      test_rst_wait();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
